// File: rtl/fsm_cmd_gen.sv
// fsm_cmd_gen: command-driven sequencer that emits timed control pulses,
// FIFO pushes and interrupt request/acknowledge handshakes.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a command (cmd_ready high)
// S_PULSE_HI  | control pulse high (COUNT -> control_counter, else control_state)
// S_PULSE_LO  | control pulse low; IDLE entry completes the low phase
// S_ERR_SETUP | error_sig asserted before the control_state pulse
// S_PUSH_WAIT | waiting for fifo1_full low to issue the single write
// S_INTR_REQ  | interruption high, waiting for acknowledge or timeout
// S_INTR_REL  | acknowledge taken, waiting for i_valid_s to drop
module fsm_cmd_gen #(
  parameter int PULSE_LEN    = 4,
  parameter int INTR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst1_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        fifo1_full,
  output logic        write_en,
  output logic [31:0] data_fifo1,
  output logic        control_counter,
  output logic        control_state,
  output logic        error_sig,
  output logic        interruption,
  output logic [2:0]  interruption_code,
  input  logic        i_valid,
  output logic [2:0]  last_i_code,
  output logic        intr_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE_HI,
    S_PULSE_LO,
    S_ERR_SETUP,
    S_PUSH_WAIT,
    S_INTR_REQ,
    S_INTR_REL
  } state_t;

  localparam logic [2:0] OP_COUNT = 3'd1;
  localparam logic [2:0] OP_STEP  = 3'd2;
  localparam logic [2:0] OP_ERROR = 3'd3;
  localparam logic [2:0] OP_PUSH  = 3'd4;
  localparam logic [2:0] OP_INTR  = 3'd5;

  // Terminal-count loads: the low phase is one cycle shorter because the
  // first IDLE cycle still shows the pulse low, keeping accept-to-ready at
  // 2*PULSE_LEN cycles.
  localparam logic [7:0] HI_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] LO_LOAD = 8'(PULSE_LEN - 2);
  localparam logic [7:0] TO_LOAD = 8'(INTR_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [2:0]  op_q;
  logic        sync1, i_valid_s;
  logic        accept;
  logic        ack_hit;
  logic        timeout_hit;

  assign accept = cmd_valid && cmd_ready;

  // Two-flop synchronizer for the asynchronous acknowledge.
  always_ff @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      sync1     <= 1'b0;
      i_valid_s <= 1'b0;
    end else begin
      sync1     <= i_valid;
      i_valid_s <= sync1;
    end
  end

  // State register and shared down-counter.
  always_ff @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_COUNT, OP_STEP: begin
              state_nxt = S_PULSE_HI;
              cnt_nxt   = HI_LOAD;
            end
            OP_ERROR: begin
              state_nxt = S_ERR_SETUP;
              cnt_nxt   = HI_LOAD;
            end
            OP_PUSH: state_nxt = S_PUSH_WAIT;
            OP_INTR: begin
              state_nxt = S_INTR_REQ;
              cnt_nxt   = TO_LOAD;
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_ERR_SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = S_PULSE_HI;
          cnt_nxt   = HI_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_PULSE_HI: begin
        if (cnt == 8'd0) begin
          state_nxt = S_PULSE_LO;
          cnt_nxt   = LO_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_PULSE_LO: begin
        if (cnt == 8'd0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      S_PUSH_WAIT: begin
        if (!fifo1_full) state_nxt = S_IDLE;
      end
      S_INTR_REQ: begin
        if (i_valid_s) begin
          ack_hit   = 1'b1;
          state_nxt = S_INTR_REL;
        end else if (cnt == 8'd0) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_INTR_REL: begin
        if (!i_valid_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; write_en is gated directly by fifo1_full.
  always_comb begin
    cmd_ready       = (state == S_IDLE);
    control_counter = (state == S_PULSE_HI) && (op_q == OP_COUNT);
    control_state   = (state == S_PULSE_HI) && (op_q != OP_COUNT);
    write_en        = (state == S_PUSH_WAIT) && !fifo1_full;
    interruption    = (state == S_INTR_REQ);
  end

  // Command capture and sticky/held output registers.
  always_ff @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      op_q              <= 3'd0;
      data_fifo1        <= 32'd0;
      interruption_code <= 3'd0;
      last_i_code       <= 3'd0;
      intr_timeout      <= 1'b0;
      error_sig         <= 1'b0;
    end else begin
      if (accept) op_q <= cmd_op;
      if (accept && cmd_op == OP_PUSH) data_fifo1 <= cmd_data;
      if (accept && cmd_op == OP_INTR) interruption_code <= cmd_data[2:0];
      if (ack_hit) last_i_code <= interruption_code;
      if (accept && cmd_op == OP_INTR) intr_timeout <= 1'b0;
      else if (timeout_hit)            intr_timeout <= 1'b1;
      // error_sig spans the whole ERROR sequence and clears once back in IDLE.
      if (accept && cmd_op == OP_ERROR) error_sig <= 1'b1;
      else if (state == S_IDLE)         error_sig <= 1'b0;
    end
  end

endmodule

// File: doc/fsm_cmd_gen.md
FSM_CMD_GEN -- requirements
Module: fsm_cmd_gen

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4: cycles each control pulse is held high and then held low (range 2..15).
REQ-002 SHALL have parameter INTR_TIMEOUT, default 255: maximum cycles spent waiting for the interrupt acknowledge (range 1..255).
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst1_n  in  1  asynchronous active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_op  in  3  opcode: 0 NOP, 1 COUNT, 2 STEP, 3 ERROR, 4 PUSH, 5 INTR; 6 and 7 are NOP.
REQ-008 cmd_data  in  32  PUSH payload; bits [2:0] give the INTR code.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 fifo1_full  in  1  downstream FIFO full.
REQ-011 write_en  out  1  FIFO write strobe.
REQ-012 data_fifo1  out  32  FIFO write data.
REQ-013 control_counter, control_state, error_sig  out  1 each  control levels to the consumer FSM.
REQ-014 interruption  out  1; interruption_code  out  3.
REQ-015 i_valid  in  1  interrupt acknowledge; asynchronous to clk.
REQ-016 last_i_code  out  3  code captured at acknowledge; intr_timeout  out  1  sticky timeout flag.

Function
REQ-017 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both high; cmd_op and cmd_data are registered on that edge.
REQ-018 SHALL synchronize i_valid through a 2-flop synchronizer (i_valid_s) before any use.
REQ-019 SHALL implement states IDLE, PULSE_HI, PULSE_LO, ERR_SETUP, PUSH_WAIT, INTR_REQ and INTR_REL with a shared 8-bit cycle counter.
REQ-020 NOP: SHALL remain in IDLE, with cmd_ready still high on the next cycle.
REQ-021 COUNT/STEP: control_counter (COUNT) or control_state (STEP) SHALL go high the cycle after accept.
REQ-022 COUNT/STEP: the signal SHALL stay high for PULSE_LEN cycles (PULSE_HI), then low for PULSE_LEN cycles (PULSE_LO), then the block returns to IDLE.
REQ-023 COUNT/STEP: each command SHALL therefore produce exactly one rising edge, with 2*PULSE_LEN cycles from accept to the next cmd_ready.
REQ-024 ERROR: error_sig SHALL go high the cycle after accept and be held PULSE_LEN cycles in ERR_SETUP.
REQ-025 ERROR: a control_state pulse per REQ-022 SHALL follow with error_sig still high; error_sig SHALL fall on entry to IDLE.
REQ-026 PUSH: data_fifo1 SHALL hold the registered cmd_data; in PUSH_WAIT, write_en SHALL be high for exactly one cycle, on the first cycle fifo1_full is low.
REQ-027 PUSH: the block SHALL return to IDLE the cycle after the write; while fifo1_full is high it SHALL wait indefinitely.
REQ-028 INTR: interruption SHALL go high the cycle after accept, with interruption_code = cmd_data[2:0], and intr_timeout SHALL clear on accept.
REQ-029 INTR_REQ: when i_valid_s=1, the block SHALL capture last_i_code, drop interruption on the next cycle and enter INTR_REL.
REQ-030 INTR_REL: SHALL wait for i_valid_s=0, then enter IDLE.
REQ-031 INTR timeout: if INTR_TIMEOUT cycles elapse in INTR_REQ without i_valid_s, SHALL drop interruption, set intr_timeout and return to IDLE.
REQ-032 If i_valid_s is already high when INTR is accepted, INTR_REQ SHALL still be entered and the acknowledge taken on its first cycle.
REQ-033 interruption_code SHALL hold its value until the next INTR accept.
REQ-034 At most one of control_counter and control_state SHALL be high in any cycle.
REQ-035 write_en SHALL never be high while fifo1_full is high.

Reset
REQ-036 When rst1_n is low, the block SHALL immediately enter IDLE.
REQ-037 When rst1_n is low, all control outputs SHALL be 0: control_counter, control_state, error_sig, interruption, write_en, intr_timeout.
REQ-038 When rst1_n is low, data_fifo1, interruption_code, last_i_code, the counter and the synchronizer SHALL all be 0.
REQ-039 Reset mid-operation SHALL abort the command without any further output activity; cmd_ready SHALL be high on the first cycle after release.

Verification
REQ-040 COUNT with PULSE_LEN=4: control_counter high cycles 1-4 after accept, low cycles 5-8, cmd_ready high at cycle 8.
REQ-041 ERROR: error_sig high cycles 1-12; control_state high cycles 5-8; no other output toggles.
REQ-042 PUSH 0xDEADBEEF with fifo1_full high for 10 cycles: write_en=0 throughout, then a single write_en with data_fifo1=0xDEADBEEF.
REQ-043 INTR with code 5 and i_valid raised 20 cycles later: interruption drops 3-4 cycles after i_valid rises; last_i_code=5; IDLE once i_valid_s is low.
REQ-044 INTR with i_valid held low: interruption drops after 255 cycles, intr_timeout=1; the next INTR accept clears it.
REQ-045 Reset asserted mid-PULSE_HI: all outputs 0 asynchronously; cmd_ready=1 on the first cycle after release.
